// File: rtl/pll_reset_sequencer.sv
// PLL lock synchroniser and system reset sequencer (hold-off after lock, flush on loss).
// Define PLL_RESET_LOSS_COUNT_EN to build the saturating lock-loss counter.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024,
    parameter int RST_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] lock_loss_count
);
    // state     | meaning
    // WAIT_LOCK | reset held, waiting for synchronised lock
    // STABLE    | lock seen, counting continuous lock cycles
    // RUN       | reset released
    // FLUSH     | lock lost, reset held for the flush length
    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN, FLUSH} state_t;

    localparam int MAX_CYCLES = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   locked_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   sys_rst_q, sys_rst_d;
    logic                   ready_q, ready_d;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};
    assign locked_s = sync_q[SYNC_STAGES-1];
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (locked_s) state_d = STABLE;
            end
            STABLE: begin
                if (!locked_s)              state_d = WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = RUN;
                else                        cnt_d   = cnt_inc;
            end
            RUN: begin
                if (!locked_s) state_d = FLUSH;
            end
            FLUSH: begin
                // Exit when the incremented count reaches the last flush cycle so
                // WAIT_LOCK is entered RST_CYCLES-1 edges after the loss.
                cnt_d = cnt_inc;
                if (cnt_inc >= RST_LAST) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
        if (state_d != state_q) cnt_d = '0;
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
        end
    end

    assign sys_rst = sys_rst_q;
    assign ready   = ready_q;

`ifdef PLL_RESET_LOSS_COUNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;
    logic       lost;

    always_comb begin
        lost       = (state_q == RUN) && !locked_s;
        loss_cnt_d = loss_cnt_q;
        if (lost && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) loss_cnt_q <= 8'd0;
        else     loss_cnt_q <= loss_cnt_d;
    end

    assign lock_loss_count = loss_cnt_q;
`else
    assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with SYNC_STAGES=2, HOLD_CYCLES=8, RST_CYCLES=4.
module tb_pll_reset_sequencer;
    localparam int HOLD    = 8;
    localparam int RSTC    = 4;
    localparam int RELEASE = 2 + HOLD;   // edges from first lock sample to release
    localparam int PULSE   = RSTC + HOLD; // sys_rst high width after a loss

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       sys_rst;
    logic       ready;
    logic [7:0] lock_loss_count;

    int n_cmp = 0;
    int n_err = 0;
    int losses = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(HOLD),
        .RST_CYCLES (RSTC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_cnt(input int n);
`ifdef PLL_RESET_LOSS_COUNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return (n >= 0) ? 8'd0 : 8'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lock is held high; first step lands on the first edge sampling it.
    task automatic expect_release(input string tag);
        for (int k = 0; k <= RELEASE; k++) begin
            step();
            chk({tag, "_sys_rst"}, {7'd0, sys_rst}, {7'd0, (k < RELEASE)});
            chk({tag, "_ready"},   {7'd0, ready},   {7'd0, (k >= RELEASE)});
        end
    endtask

    // From RUN: one-cycle lock drop, then full reset pulse and release.
    task automatic loss_pulse(input string tag);
        pll_locked = 1'b0;
        step();
        chk({tag, "_f0"}, {7'd0, sys_rst}, 8'd0);
        pll_locked = 1'b1;
        step();
        chk({tag, "_f1"}, {7'd0, sys_rst}, 8'd0);
        losses++;
        for (int k = 0; k <= PULSE; k++) begin
            step();
            chk({tag, "_pulse"}, {7'd0, sys_rst}, {7'd0, (k < PULSE)});
            if (k == 0 || k == PULSE) chk({tag, "_cnt"}, lock_loss_count, exp_cnt(losses));
        end
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b1;

        // Reset held with lock present
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_sys_rst", {7'd0, sys_rst}, 8'd1);
            chk("rst_ready",   {7'd0, ready},   8'd0);
            chk("rst_cnt",     lock_loss_count, 8'd0);
        end
        rst = 1'b0;
        expect_release("powerup");
        chk("powerup_cnt", lock_loss_count, 8'd0);

        // Acquisition glitch while in STABLE
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("glitch_pre", {7'd0, sys_rst}, 8'd1);
        end
        pll_locked = 1'b0;
        step();
        chk("glitch_low", {7'd0, sys_rst}, 8'd1);
        pll_locked = 1'b1;
        expect_release("glitch");
        chk("glitch_cnt", lock_loss_count, 8'd0);

        // Loss in RUN, single-cycle drop
        loss_pulse("loss1");

        // Loss held low for 50 cycles
        pll_locked = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("held_sys_rst", {7'd0, sys_rst}, {7'd0, (i >= 2)});
            if (i == 2) losses++;
            if (i >= 2) chk("held_cnt", lock_loss_count, exp_cnt(losses));
        end
        pll_locked = 1'b1;
        expect_release("held");
        chk("held_cnt_end", lock_loss_count, exp_cnt(losses));

        // Reset mid-FLUSH after the third loss
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        step();
        losses++;
        chk("flush_entry", {7'd0, sys_rst}, 8'd1);
        chk("flush_cnt3", lock_loss_count, exp_cnt(3));
        step();
        rst = 1'b1;
        step();
        chk("flushrst_sys_rst", {7'd0, sys_rst}, 8'd1);
        chk("flushrst_ready",   {7'd0, ready},   8'd0);
        chk("flushrst_cnt",     lock_loss_count, 8'd0);
        rst    = 1'b0;
        losses = 0;
        expect_release("flushrst");

        // Saturation over 300 losses
        for (int i = 0; i < 300; i++) loss_pulse("sat");
        chk("sat_final", lock_loss_count, exp_cnt(300));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Consumes the asynchronous `locked` flag from the clock PLL and generates the design-wide synchronous reset in the PLL output clock domain. It holds `sys_rst` asserted until lock has been continuously stable for a programmable hold time, then releases it. On loss of lock it re-asserts `sys_rst` for a guaranteed minimum width and re-runs the sequence. It sits directly after the PLL in each top level and feeds every synthesis block's reset.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser flops on `pll_locked`; legal range ≥2.
- `HOLD_CYCLES`, 1024: consecutive synchronised-lock cycles required before release; legal range ≥1.
- `RST_CYCLES`, 16: minimum flush length after a lock loss; legal range ≥1.

Ports:
- `clk`  in  1  PLL output clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pll_locked`  in  1  PLL lock flag; asynchronous to `clk`.
- `sys_rst`  out  1  registered, active-high system reset.
- `ready`  out  1  registered; always equals `!sys_rst`.
- `lock_loss_count`  out  8  saturating count of lock losses seen in RUN.

## Operation
- Synchroniser:
  - `pll_locked` passes through `SYNC_STAGES` flops. The last flop is `locked_s`.
  - All synchroniser flops clear to 0 on `rst`.
- Counter `cnt`:
  - Width is `$clog2(max(HOLD_CYCLES,RST_CYCLES))+1`.
  - Clears to 0 on every state entry.
- FSM states:
  - WAIT_LOCK: if `locked_s`, go to STABLE.
  - STABLE: if `!locked_s`, go to WAIT_LOCK. This is an acquisition glitch and is not counted. Else, if `cnt==HOLD_CYCLES-1`, go to RUN. Else `cnt++`.
  - RUN: if `!locked_s`, go to FLUSH and increment `lock_loss_count`. The count saturates at 255.
  - FLUSH: `cnt++` regardless of `locked_s`. When `cnt==RST_CYCLES-1`, go to WAIT_LOCK.
- Outputs:
  - `sys_rst=1` and `ready=0` in every state except RUN.
  - Outputs are registered, so they reflect the state entered at the same edge.
- `rst` overrides everything at the next edge, including `rst` mid-FLUSH or mid-STABLE:
  - state goes to WAIT_LOCK;
  - `cnt=0`, `lock_loss_count=0`;
  - synchroniser flops are cleared;
  - `sys_rst=1`, `ready=0`.
- Reset values: `sys_rst=1`, `ready=0`, `lock_loss_count=0`.

## Timing
- Let E0 be the first edge that samples `pll_locked=1`.
  - `locked_s` rises after edge E(SYNC_STAGES-1).
  - STABLE is entered at E(SYNC_STAGES).
  - `sys_rst` falls at E(SYNC_STAGES+HOLD_CYCLES).
- Loss: let Ex be the edge at which RUN samples `locked_s=0`.
  - `sys_rst` rises at Ex.
  - WAIT_LOCK is entered at Ex+RST_CYCLES-1.
  - If lock is already stable, `sys_rst` falls at Ex+RST_CYCLES+HOLD_CYCLES.
  - The minimum `sys_rst` pulse is RST_CYCLES+HOLD_CYCLES cycles.
- Loss-to-assert latency from the `pll_locked` fall is SYNC_STAGES+1 edges.
- `lock_loss_count` updates on the same edge as the FLUSH entry.
- A 1-cycle `pll_locked` drop is always captured: the first flop samples it at the edge where it is low.

## Configuration
- Macro: `PLL_RESET_LOSS_COUNT_EN`.
- Defined: the 8-bit saturating `lock_loss_count` register is implemented as described.
- Undefined: no counter register is built and `lock_loss_count` is tied to 8'd0. The FSM and all reset timing are identical in both builds.

## Test plan
Settings: `SYNC_STAGES=2`, `HOLD_CYCLES=8`, `RST_CYCLES=4`, macro defined unless stated.
- **Reset and power-up lock.** Hold `rst=1` with `pll_locked=1` for 5 cycles: `sys_rst=1`, `ready=0`, count=0 throughout. Release `rst` with lock steady: `sys_rst` falls exactly 10 edges after the first post-reset sample of lock, and `ready` rises on the same edge.
- **Acquisition glitch.** Drop `pll_locked` for 1 cycle while in STABLE: FSM returns to WAIT_LOCK and count stays 0. Release occurs 10 edges after lock resumes being sampled.
- **Loss in RUN.** In RUN, drop `pll_locked` for 1 cycle: `sys_rst` rises 3 edges after the fall, stays high exactly 12 cycles, then falls; count=1.
- **Loss held low.** In RUN, hold `pll_locked=0` for 50 cycles: `sys_rst` stays high throughout with count=1. Release falls 10 edges after lock returns.
- **Saturation.** Cause 300 RUN losses: count reads 255 and stays there. With the macro undefined, the same stimulus gives count=0 and identical `sys_rst` timing.
- **Reset mid-FLUSH.** Assert `rst` during FLUSH with count=3: next edge gives WAIT_LOCK, count=0, `sys_rst=1`. Release needs the full 10 edges after lock is re-sampled.
